// File: rtl/spin_init_drive_if.sv
// Handshake and drive bundle between the spin-init controller and its requester.
// The master modport issues requests; the slave modport is the controller side.
interface spin_init_drive_if #(
  parameter int unsigned N = 3
);
  logic          start;
  logic          abort;
  logic [N-1:0]  spin_target;
  logic [15:0]   half_period;
  logic [31:0]   hold_cycles;
  logic [N-1:0]  drive_en;
  logic [N-1:0]  drive_val;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, spin_target, half_period, hold_cycles,
    input  drive_en, drive_val, busy, done
  );

  modport slave (
    input  start, abort, spin_target, half_period, hold_cycles,
    output drive_en, drive_val, busy, done
  );
endinterface

// File: rtl/spin_init_drive.sv
// Drives each oscillator line with a reference square wave, in phase or inverted
// per target spin, then releases on the end of a full reference period.
module spin_init_drive #(
  parameter int unsigned N = 3
) (
  input  logic             clk,
  input  logic             rst,
  spin_init_drive_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, ALIGN} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  spin_q, spin_d;
  logic [15:0]   p_q, p_d;
  logic [31:0]   h_q, h_d;
  logic [15:0]   hp_cnt_q, hp_cnt_d;
  logic [31:0]   hold_cnt_q, hold_cnt_d;
  logic          ref_q, ref_d;
  logic [N-1:0]  drive_en_q, drive_en_d;
  logic [N-1:0]  drive_val_q, drive_val_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          hp_wrap;
  logic          hold_met;
  logic          last_cycle;

  // Counters describe the drive cycle currently on the outputs; the last cycle
  // is the end of a ref=1 half once at least H cycles have been driven.
  always_comb begin
    state_d     = state_q;
    spin_d      = spin_q;
    p_d         = p_q;
    h_d         = h_q;
    hp_cnt_d    = hp_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    ref_d       = ref_q;
    drive_en_d  = '0;
    drive_val_d = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    hp_wrap    = (hp_cnt_q == p_q - 16'd1);
    hold_met   = (hold_cnt_q >= h_q - 32'd1);
    last_cycle = hold_met && hp_wrap && ref_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d     = DRIVE;
          spin_d      = bus.spin_target;
          p_d         = (bus.half_period == 16'd0) ? 16'd1 : bus.half_period;
          h_d         = (bus.hold_cycles == 32'd0) ? 32'd1 : bus.hold_cycles;
          hp_cnt_d    = '0;
          hold_cnt_d  = '0;
          ref_d       = 1'b0;
          drive_en_d  = '1;
          drive_val_d = ~bus.spin_target;
          busy_d      = 1'b1;
        end
      end
      DRIVE, ALIGN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (last_cycle) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          if (state_q == DRIVE && hold_met) state_d = ALIGN;
          hp_cnt_d    = hp_wrap ? 16'd0 : hp_cnt_q + 16'd1;
          ref_d       = hp_wrap ? ~ref_q : ref_q;
          hold_cnt_d  = (hold_cnt_q == h_q) ? h_q : hold_cnt_q + 32'd1;
          drive_en_d  = '1;
          drive_val_d = {N{ref_d}} ^ ~spin_q;
          busy_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      spin_q      <= '0;
      p_q         <= '0;
      h_q         <= '0;
      hp_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      ref_q       <= 1'b0;
      drive_en_q  <= '0;
      drive_val_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      spin_q      <= spin_d;
      p_q         <= p_d;
      h_q         <= h_d;
      hp_cnt_q    <= hp_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      ref_q       <= ref_d;
      drive_en_q  <= drive_en_d;
      drive_val_q <= drive_val_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.drive_en  = drive_en_q;
  assign bus.drive_val = drive_val_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_spin_init_drive.sv
// Directed bench for spin_init_drive with N=3; outputs sampled on falling edges.
module tb_spin_init_drive;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  spin_init_drive_if #(.N(3)) bus ();

  spin_init_drive #(.N(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a falling edge; leaves the bench at the falling edge of drive cycle k=0.
  task automatic start_run(input logic [2:0] spin, input logic [15:0] p, input logic [31:0] h);
    bus.start       = 1'b1;
    bus.spin_target = spin;
    bus.half_period = p;
    bus.hold_cycles = h;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Checks L drive cycles with ref = floor(k/p) mod 2, then the done cycle.
  // inj_k >= 0 injects a conflicting start request sampled at the end of cycle inj_k.
  task automatic drive_check(input string tag, input logic [2:0] spin, input int p,
                             input int len, input int inj_k);
    logic r;
    for (int k = 0; k < len; k++) begin
      if (k == inj_k + 1) bus.start = 1'b0;
      r = ((k / p) % 2) == 1;
      chk({tag, "_en"},   {29'd0, bus.drive_en}, 32'd7);
      chk({tag, "_val"},  {29'd0, bus.drive_val}, {29'd0, {3{r}} ^ ~spin});
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
      if (k == inj_k) begin
        bus.start       = 1'b1;
        bus.spin_target = ~spin;
        bus.half_period = 16'd1;
        bus.hold_cycles = 32'd50;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_done_idle"}, {26'd0, bus.drive_en, bus.drive_val}, 32'd0);
    chk({tag, "_done_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] ref_tbl;
    logic       r;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.spin_target = '0;
    bus.half_period = '0;
    bus.hold_cycles = '0;

    // Reset, then idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outs", {24'd0, bus.drive_en, bus.drive_val, bus.busy, bus.done}, 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outs", {24'd0, bus.drive_en, bus.drive_val, bus.busy, bus.done}, 32'd0);
    end

    // P=2, H=5, target 101: 8 drive cycles, ref 0,0,1,1,0,0,1,1
    ref_tbl = 8'b1100_1100;
    start_run(3'b101, 16'd2, 32'd5);
    for (int k = 0; k < 8; k++) begin
      r = ref_tbl[k];
      chk("p2h5_en",   {29'd0, bus.drive_en}, 32'd7);
      chk("p2h5_val",  {29'd0, bus.drive_val}, {29'd0, r, ~r, r});
      chk("p2h5_busy", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
    end
    chk("p2h5_done", {31'd0, bus.done}, 32'd1);
    chk("p2h5_busy_end", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    chk("p2h5_done_once", {31'd0, bus.done}, 32'd0);

    // P=0, H=0 clamp to 1: two cycles, ref 0 then 1
    start_run(3'b111, 16'd0, 32'd0);
    drive_check("p0h0", 3'b111, 1, 2, -1);
    @(negedge clk);

    // P=3, H=6 aligned; start at k=3 is ignored
    start_run(3'b011, 16'd3, 32'd6);
    drive_check("p3h6", 3'b011, 3, 6, 2);
    @(negedge clk);
    chk("p3h6_no_rerun", {31'd0, bus.busy}, 32'd0);

    // Abort at k=10 of a long run
    start_run(3'b000, 16'd4, 32'd100);
    for (int k = 0; k <= 10; k++) begin
      r = ((k / 4) % 2) == 1;
      chk("abort_val", {29'd0, bus.drive_val}, {29'd0, {3{r}} ^ 3'b111});
      if (k == 10) bus.abort = 1'b1;
      @(negedge clk);
    end
    bus.abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("abort_outs", {24'd0, bus.drive_en, bus.drive_val, bus.busy, bus.done}, 32'd0);
      @(negedge clk);
    end

    // start together with abort in IDLE: no run
    bus.abort = 1'b1;
    start_run(3'b101, 16'd2, 32'd5);
    bus.abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("start_abort_idle", {30'd0, bus.busy, bus.drive_en[0]}, 32'd0);
      @(negedge clk);
    end

    // Back-to-back: new start in the done cycle
    start_run(3'b101, 16'd1, 32'd2);
    drive_check("b2b_a", 3'b101, 1, 2, -1);
    start_run(3'b010, 16'd2, 32'd3);
    drive_check("b2b_b", 3'b010, 2, 4, -1);
    @(negedge clk);
    chk("final_idle", {24'd0, bus.drive_en, bus.drive_val, bus.busy, bus.done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spin_init_drive.md
# spin_init_drive

Writes initial spin states into the Ising oscillator array. It is the write-side counterpart of the phase sampler, which reads relative phases out of the array. On `start`, the block drives every spin line with a common reference square wave. Each spin is driven either in phase with the reference (spin 1) or inverted (spin 0) for a programmed number of cycles. It then releases the lines on a clean period boundary and pulses `done`. The array is then left to anneal, and the sampler reads the result.

## Interface
- `N`, default 3: number of spins / drive lines.
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request; accepted only in IDLE.
- `abort`  in  1: immediate termination of a run; no `done` pulse.
- `spin_target`  in  N: desired spin values (1 = in phase with reference); latched on accept.
- `half_period`  in  16: reference half-period P in clk cycles; latched on accept; 0 is treated as 1.
- `hold_cycles`  in  32: minimum drive length H in cycles; latched on accept; 0 is treated as 1.
- `drive_en`  out  N: all ones while driving, else 0.
- `drive_val`  out  N: per-spin drive level; 0 when not driving.
- `busy`  out  1: high in every state other than IDLE.
- `done`  out  1: one-cycle pulse after a normally completed run.

## Operation
- States:
  - IDLE: default state.
  - DRIVE: reference is running and the hold count is incrementing.
  - ALIGN: hold count is satisfied; the block waits for the end of the current full reference period.
- All outputs are registered.
- Reset (synchronous, `rst`=1 at an edge):
  - state = IDLE.
  - `drive_en`, `drive_val`, `busy`, `done` = 0.
  - All counters and latched values = 0.
- IDLE → DRIVE when `start`=1 and `abort`=0.
  - On this transition, latch `spin_target`, P (clamped ≥1) and H (clamped ≥1).
  - Clear the half-period counter and the hold counter; set ref = 0.
- Drive cycle index k starts at 0 on the first cycle `drive_en` is high.
  - ref(k) = floor(k/P) mod 2. The half-period counter counts 0..P-1 and toggles ref at wrap.
  - `drive_val[i]` = ref XOR ~spin_target_latched[i].
- DRIVE → ALIGN after H drive cycles. In ALIGN, driving continues unchanged.
- Run end: the last drive cycle is the smallest k ≥ H-1 with k mod 2P = 2P-1, i.e. the end of a ref=1 half. In that cycle:
  - Next state = IDLE.
  - Next cycle: `drive_en`/`drive_val`/`busy` = 0 and `done` = 1 for exactly one cycle.
  - If k = H-1 already satisfies the period condition, ALIGN is skipped.
- Hold counter width: 32 bits. It saturates at H and never wraps. Maximum H = 2^32-1.
- `start` while busy: ignored. The latched values do not change.
- `abort`=1 in DRIVE/ALIGN:
  - Next cycle: IDLE, all outputs 0, no `done`.
- `abort`=1 in IDLE: ignored, and it overrides a simultaneous `start` (no run begins).
- `start` in the `done` cycle: accepted, because the state is IDLE. `drive_en` rises in the following cycle.
- Input changes during a run have no effect, since values are latched.
- `rst` mid-run: same as reset; outputs 0 at the next cycle, no `done`.

## Timing
- `start` sampled at edge T:
  - `busy`, `drive_en` high from cycle T+1 (k=0).
  - First ref toggle occurs at k=P.
- Run length = smallest multiple of 2P that is ≥ H, in cycles.
- `done` is high in the cycle immediately after the last drive cycle, together with `busy`=0.
- Abort or reset latency: outputs clear one edge after the edge that samples `abort`/`rst`.
- Throughput: a back-to-back `start` in the `done` cycle gives one idle cycle between runs (the `done` cycle itself).

## Test plan
- Reset then idle: hold `rst` 3 cycles, then hold `start`=0 for 10 cycles → all outputs 0 throughout.
- N=3, P=2, H=5, spin_target=3'b101:
  - `drive_en`=3'b111 for 8 cycles.
  - `drive_val[0]` and `drive_val[2]` = 0,0,1,1,0,0,1,1; `drive_val[1]` = 1,1,0,0,1,1,0,0.
  - `done` in cycle 9; `busy` high exactly 8 cycles.
- P=0, H=0: treated as P=1, H=1 → 2 drive cycles with ref 0,1, then `done`.
- P=3, H=6 (aligned): 6 drive cycles, no ALIGN cycles, `done` at cycle 7. A `start` pulse at cycle 3 is ignored: latched target unchanged and run length unchanged.
- Abort:
  - P=4, H=100, `abort` at k=10 → `drive_en`=0 and `busy`=0 from k=11, `done` never asserted.
  - A simultaneous `start`+`abort` in IDLE → stays IDLE.
- Back-to-back: a second `start` (new target 3'b010) in the `done` cycle → `drive_en` high the next cycle with the new polarity pattern and ref restarting at 0.
